// File: rtl/key_press_classifier.sv
// Key gesture classifier: turns the debounced active-low key level into
// single-click, double-click and long-press pulses.
module key_press_classifier #(
    parameter int unsigned LONG_CYC = 12_000_000,
    parameter int unsigned GAP_CYC  = 3_600_000,
    parameter int unsigned CNT_W    = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic key_db_n,
    output logic single_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        DOWN1,
        HOLD,
        GAP,
        DOWN2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             key_d;
    logic             press;
    logic             release_e;
    logic             single_nx;
    logic             double_nx;
    logic             long_nx;

    assign press     = key_d & ~key_db_n;
    assign release_e = ~key_d & key_db_n;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        single_nx = 1'b0;
        double_nx = 1'b0;
        long_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (press) begin
                    state_nx = DOWN1;
                    cnt_nx   = '0;
                end
            end
            DOWN1: begin
                // A release on the terminal cycle still counts as short.
                if (release_e) begin
                    state_nx = GAP;
                    cnt_nx   = '0;
                end else if (cnt == LONG_LAST) begin
                    state_nx = HOLD;
                    long_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (release_e) begin
                    state_nx = IDLE;
                end
            end
            GAP: begin
                // A second press on the terminal cycle still makes a double.
                if (press) begin
                    state_nx = DOWN2;
                    cnt_nx   = '0;
                end else if (cnt == GAP_LAST) begin
                    state_nx  = IDLE;
                    single_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DOWN2: begin
                if (release_e) begin
                    state_nx  = IDLE;
                    double_nx = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            key_d        <= 1'b1;
            single_pulse <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            key_d        <= key_db_n;
            single_pulse <= single_nx;
            double_pulse <= double_nx;
            long_pulse   <= long_nx;
            busy         <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_key_press_classifier.sv
// Bench for key_press_classifier: gesture-level reference model over
// per-edge key levels, directed boundary cases plus random gestures.
module tb_key_press_classifier;

    localparam int LONG_CYC = 20;
    localparam int GAP_CYC  = 10;
    localparam int CNT_W    = 8;

    logic clk = 1'b0;
    logic rst;
    logic key_db_n;
    logic single_pulse;
    logic double_pulse;
    logic long_pulse;
    logic busy;

    int errs   = 0;
    int checks = 0;

    // Key level presented at each clock edge, and expected
    // {single, double, long, busy} right after that edge.
    bit         lv[$];
    logic [3:0] ex[$];

    key_press_classifier #(
        .LONG_CYC(LONG_CYC),
        .GAP_CYC (GAP_CYC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_db_n    (key_db_n),
        .single_pulse(single_pulse),
        .double_pulse(double_pulse),
        .long_pulse  (long_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] obs();
        return {single_pulse, double_pulse, long_pulse, busy};
    endfunction

    task automatic seg(input bit v, input int len);
        for (int i = 0; i < len; i++) lv.push_back(v);
    endtask

    task automatic set_busy(input int a, input int b);
        for (int j = a; j < b; j++)
            if (j < ex.size()) ex[j] = ex[j] | 4'b0001;
    endtask

    task automatic set_bit(input int idx, input logic [3:0] m);
        if (idx < ex.size()) ex[idx] = ex[idx] | m;
    endtask

    // Classify each gesture from run lengths: a press of D low edges is
    // long iff D > LONG_CYC; a release gap of H high edges ends the gesture
    // as single iff H > GAP_CYC, otherwise the next press makes a double.
    task automatic predict();
        int n;
        int k;
        int p;
        int r;
        int q;
        int r2;
        n = lv.size();
        ex.delete();
        for (int i = 0; i < n; i++) ex.push_back(4'b0000);
        k = 1;
        while (k < n) begin
            p = k;
            while (p < n && !(lv[p] == 1'b0 && lv[p-1] == 1'b1)) p++;
            if (p >= n) break;
            r = p;
            while (r < n && lv[r] == 1'b0) r++;
            if (r - p > LONG_CYC) begin
                set_bit(p + LONG_CYC, 4'b0010);
                set_busy(p, r);
                k = r;
            end else begin
                q = r;
                while (q < n && lv[q] == 1'b1) q++;
                if (q - r > GAP_CYC) begin
                    set_bit(r + GAP_CYC, 4'b1000);
                    set_busy(p, r + GAP_CYC);
                    k = q;
                end else begin
                    r2 = q;
                    while (r2 < n && lv[r2] == 1'b0) r2++;
                    set_bit(r2, 4'b0100);
                    set_busy(p, r2);
                    k = r2;
                end
            end
        end
    endtask

    task automatic run_stream(input string name);
        predict();
        for (int k = 0; k < lv.size(); k++) begin
            key_db_n = lv[k];
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (obs() !== ex[k]) begin
                errs++;
                $display("FAIL %s edge %0d: got sdlb=%b want %b",
                         name, k, obs(), ex[k]);
            end
        end
        lv.delete();
    endtask

    task automatic step_check(input string name, input logic [3:0] want);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs() !== want) begin
            errs++;
            $display("FAIL %s: got sdlb=%b want %b", name, obs(), want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        key_db_n = 1'b1;
        repeat (2) step_check("reset_idle", 4'b0000);
        key_db_n = 1'b0;
        step_check("reset_key_low", 4'b0000);
        key_db_n = 1'b1;
        step_check("reset_hold", 4'b0000);
        rst = 1'b1;
        step_check("reset_release", 4'b0000);
    endtask

    task automatic test_single();
        seg(1, 3); seg(0, 5); seg(1, 20);
        run_stream("single");
        seg(1, 2); seg(0, 1); seg(1, 20);
        run_stream("single_1cyc");
    endtask

    task automatic test_double();
        seg(1, 3); seg(0, 5); seg(1, 4); seg(0, 5); seg(1, 20);
        run_stream("double");
        seg(1, 2); seg(0, 3); seg(1, 1); seg(0, 30); seg(1, 20);
        run_stream("double_long2nd");
    endtask

    task automatic test_long();
        seg(1, 3); seg(0, 40); seg(1, 20);
        run_stream("long");
    endtask

    task automatic test_long_boundary();
        seg(1, 3);
        seg(0, LONG_CYC - 1); seg(1, 20);
        seg(0, LONG_CYC);     seg(1, 20);
        seg(0, LONG_CYC + 1); seg(1, 20);
        run_stream("long_boundary");
    endtask

    task automatic test_gap_boundary();
        seg(1, 3);
        seg(0, 5); seg(1, GAP_CYC);     seg(0, 5); seg(1, 20);
        seg(0, 5); seg(1, GAP_CYC + 1); seg(0, 5); seg(1, 20);
        run_stream("gap_boundary");
    endtask

    task automatic test_back_to_back();
        seg(1, 3); seg(0, 5); seg(1, 3); seg(0, 5);
        seg(1, 2); seg(0, 4); seg(1, 20);
        run_stream("third_press");
    endtask

    task automatic test_reset_mid();
        key_db_n = 1'b1;
        step_check("mid_pre", 4'b0000);
        key_db_n = 1'b0;
        repeat (4) @(posedge clk);
        step_check("mid_down1_busy", 4'b0001);
        rst = 1'b0;
        key_db_n = 1'b1;
        step_check("mid_down1_rst", 4'b0000);
        rst = 1'b1;
        repeat (GAP_CYC + 5) step_check("mid_down1_after", 4'b0000);
        key_db_n = 1'b0;
        repeat (4) @(posedge clk);
        key_db_n = 1'b1;
        repeat (2) @(posedge clk);
        step_check("mid_gap_busy", 4'b0001);
        rst = 1'b0;
        step_check("mid_gap_rst", 4'b0000);
        rst = 1'b1;
        repeat (GAP_CYC + 5) step_check("mid_gap_after", 4'b0000);
        seg(1, 2); seg(0, 6); seg(1, 20);
        run_stream("mid_recover");
    endtask

    task automatic test_random();
        for (int s = 0; s < 12; s++) begin
            seg(1, 3);
            for (int g = 0; g < 8; g++) begin
                seg(0, $urandom_range(1, LONG_CYC + 12));
                seg(1, $urandom_range(1, GAP_CYC + 6));
            end
            seg(1, GAP_CYC + 8);
            run_stream($sformatf("random%0d", s));
        end
    endtask

    initial begin
        rst = 1'b0;
        key_db_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_double();
        test_long();
        test_long_boundary();
        test_gap_boundary();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
